// File: rtl/dance_round_sequencer.sv
// Round controller: IDLE/RUN/PAUSE/OVER FSM, step tick generator, speed ramp and health bar.
// All outputs registered; state changes land on the clk edge after the causing pulse.
module dance_round_sequencer #(
  parameter int BASE_PERIOD   = 50_000_000,
  parameter int STEP_DELTA    = 5_000_000,
  parameter int RAMP_MAX      = 40_000_000,
  parameter int RAMP_MIN      = 15_000_000,
  parameter int RAMP_DOWN     = 10_000_000,
  parameter int RAMP_INTERVAL = 500_000_000,
  parameter int HEALTH_INIT   = 8,
  parameter int HEALTH_MAX    = 13,
  parameter int HEALTH_MIN    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start_pulse,
  input  logic        i_pause_pulse,
  input  logic [2:0]  i_hits,
  input  logic [2:0]  i_empties,
  output logic        o_step_tick,
  output logic [26:0] o_redux,
  output logic [3:0]  o_health,
  output logic [1:0]  o_state,
  output logic        o_game_over
);

  localparam int RW = $clog2(RAMP_INTERVAL);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_INTERVAL - 1);
  localparam logic [26:0] P_BASE  = 27'(BASE_PERIOD);
  localparam logic [26:0] P_DELTA = 27'(STEP_DELTA);
  localparam logic [26:0] P_RMAX  = 27'(RAMP_MAX);
  localparam logic [26:0] P_RMIN  = 27'(RAMP_MIN);
  localparam logic [26:0] P_RDOWN = 27'(RAMP_DOWN);
  localparam logic [3:0]  H_INIT  = 4'(HEALTH_INIT);
  localparam logic [3:0]  H_MAX   = 4'(HEALTH_MAX);
  localparam logic [3:0]  H_MIN   = 4'(HEALTH_MIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_step_tick;
  logic [26:0]   r_redux;
  logic [3:0]    r_health;
  logic          r_game_over;
  logic          r_dir_up;
  logic [26:0]   r_scnt;
  logic [RW-1:0] r_rcnt;

  logic          w_run_stay, w_round_init, w_lose;
  logic [2:0]    w_active, w_hit;
  logic          w_score, w_all_hit;
  logic [26:0]   w_period;

  assign w_active  = ~i_empties;
  assign w_hit     = i_hits & w_active;
  assign w_all_hit = (w_hit == w_active);
  // Lane results only count while the previous edge raised the tick.
  assign w_score   = r_step_tick && (w_active != 3'b000);
  assign w_lose    = w_score && !w_all_hit && (r_health == H_MIN);
  assign w_period  = P_BASE - r_redux;

  always_comb begin
    w_state_nxt  = r_state;
    w_run_stay   = 1'b0;
    w_round_init = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start_pulse) begin
          w_state_nxt  = S_RUN;
          w_round_init = 1'b1;
        end
      end
      S_RUN: begin
        if (i_start_pulse)      w_state_nxt = S_IDLE;
        else if (i_pause_pulse) w_state_nxt = S_PAUSE;
        else begin
          w_run_stay = 1'b1;
          if (w_lose) w_state_nxt = S_OVER;
        end
      end
      S_PAUSE: begin
        if (i_start_pulse)      w_state_nxt = S_IDLE;
        else if (i_pause_pulse) w_state_nxt = S_RUN;
      end
      S_OVER: begin
        if (i_start_pulse) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_game_over <= (w_state_nxt == S_OVER);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_step_tick <= 1'b0;
      r_redux     <= '0;
      r_health    <= H_INIT;
      r_dir_up    <= 1'b1;
      r_scnt      <= '0;
      r_rcnt      <= '0;
    end else begin
      r_step_tick <= 1'b0;
      if (w_round_init) begin
        r_redux  <= '0;
        r_health <= H_INIT;
        r_dir_up <= 1'b1;
        r_scnt   <= '0;
        r_rcnt   <= '0;
      end else if (w_run_stay) begin
        // Compare uses this cycle's period, so a ramp in the same cycle only affects later steps.
        if (r_scnt >= w_period - 27'd1) begin
          r_step_tick <= 1'b1;
          r_scnt      <= '0;
        end else begin
          r_scnt <= r_scnt + 27'd1;
        end

        if (r_rcnt == RAMP_LAST) begin
          r_rcnt <= '0;
          if (r_dir_up) begin
            if (r_redux < P_RMAX) r_redux  <= r_redux + P_DELTA;
            else                  r_dir_up <= 1'b0;
          end else begin
            if (r_redux > P_RMIN) r_redux  <= r_redux - P_RDOWN;
            else                  r_dir_up <= 1'b1;
          end
        end else begin
          r_rcnt <= r_rcnt + 1'b1;
        end

        if (w_score) begin
          if (w_all_hit) begin
            if (r_health < H_MAX) r_health <= r_health + 4'd1;
          end else if (r_health != H_MIN) begin
            r_health <= r_health - 4'd1;
          end
        end
      end
    end
  end

  assign o_step_tick = r_step_tick;
  assign o_redux     = r_redux;
  assign o_health    = r_health;
  assign o_state     = r_state;
  assign o_game_over = r_game_over;

endmodule

// File: tb/tb_dance_round_sequencer.sv
// Randomized and directed bench for dance_round_sequencer against a cycle-level behavioural model.
module tb_dance_round_sequencer;

  localparam int BP = 20, SD = 2, RMAX = 8, RMIN = 3, RD = 4, RI = 100;
  localparam int HI = 8, HM = 13, HN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start_pulse = 1'b0, pause_pulse = 1'b0;
  logic [2:0]  hits = 3'b000, empties = 3'b111;
  logic        step_tick, game_over;
  logic [26:0] redux;
  logic [3:0]  health;
  logic [1:0]  state;

  dance_round_sequencer #(
    .BASE_PERIOD(BP), .STEP_DELTA(SD), .RAMP_MAX(RMAX), .RAMP_MIN(RMIN),
    .RAMP_DOWN(RD), .RAMP_INTERVAL(RI), .HEALTH_INIT(HI), .HEALTH_MAX(HM),
    .HEALTH_MIN(HN)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start_pulse(start_pulse),
    .i_pause_pulse(pause_pulse), .i_hits(hits), .i_empties(empties),
    .o_step_tick(step_tick), .o_redux(redux), .o_health(health),
    .o_state(state), .o_game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks    = 0;

  // Model: cycles of RUN since last tick, total RUN cycles since the last ramp event.
  int m_state, m_redux, m_health, m_since, m_runcyc;
  bit m_tick, m_up;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_step(input bit rst, input bit st, input bit pa,
                        input logic [2:0] h, input logic [2:0] e);
    bit nt;
    logic [2:0] act;
    nt = 1'b0;
    if (rst) begin
      m_state = 0; m_redux = 0; m_health = HI; m_since = 0; m_runcyc = 0; m_up = 1'b1;
    end else begin
      case (m_state)
        0: if (st) begin
             m_state = 1; m_redux = 0; m_health = HI; m_since = 0; m_runcyc = 0; m_up = 1'b1;
           end
        1: if (st) m_state = 0;
           else if (pa) m_state = 2;
           else begin
             act = ~e;
             if (m_tick && act != 3'b000) begin
               if ((h & act) == act) m_health = (m_health + 1 > HM) ? HM : m_health + 1;
               else if (m_health == HN) m_state = 3;
               else m_health = m_health - 1;
             end
             m_since++;
             if (m_since >= BP - m_redux) begin
               nt = 1'b1;
               m_since = 0;
             end
             m_runcyc++;
             if (m_runcyc == RI) begin
               m_runcyc = 0;
               if (m_up) begin
                 if (m_redux < RMAX) m_redux += SD; else m_up = 1'b0;
               end else begin
                 if (m_redux > RMIN) m_redux -= RD; else m_up = 1'b1;
               end
             end
           end
        2: if (st) m_state = 0;
           else if (pa) m_state = 1;
        default: if (st) m_state = 0;
      endcase
    end
    m_tick = nt;
  endtask

  task automatic cyc(input bit rst, input bit st, input bit pa,
                     input logic [2:0] h, input logic [2:0] e);
    reset = rst; start_pulse = st; pause_pulse = pa; hits = h; empties = e;
    @(posedge clk);
    m_step(rst, st, pa, h, e);
    @(negedge clk);
    chk("tick", step_tick, m_tick);
    chk("redux", redux, m_redux);
    chk("health", health, m_health);
    chk("state", state, m_state);
    chk("game_over", game_over, m_state == 3);
    if (step_tick) ticks++;
  endtask

  task automatic run_to_tick();
    for (int k = 0; k < 100; k++) begin
      cyc(0, 0, 0, 3'b000, 3'b111);
      if (step_tick) return;
    end
    chk("tick_timeout", 0, 1);
  endtask

  int exp_r[10] = '{2, 4, 6, 8, 8, 4, 0, 0, 2, 4};
  int h_up[6]   = '{9, 10, 11, 12, 13, 13};
  int t0, k;

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 3'b000, 3'b111);
    cyc(1, 0, 0, 3'b000, 3'b111);
    chk("rst_state", state, 0);
    chk("rst_health", health, HI);

    // First tick 20 cycles after entry, then every 20.
    cyc(0, 1, 0, 3'b000, 3'b111);
    t0 = ticks;
    for (int i = 1; i <= 60; i++) begin
      cyc(0, 0, 0, 3'b000, 3'b111);
      if (i == 19) chk("no_early_tick", ticks - t0, 0);
      if (i == 20) chk("first_tick", step_tick, 1);
    end
    chk("ticks_in_60", ticks - t0, 3);

    // Pause at counter 7, resume, next tick 13 cycles later.
    run_to_tick();
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 3'b000, 3'b111);
    cyc(0, 0, 1, 3'b000, 3'b111);
    t0 = ticks;
    for (int i = 0; i < 50; i++) cyc(0, 0, 0, 3'b000, 3'b111);
    chk("pause_ticks", ticks - t0, 0);
    chk("pause_state", state, 2);
    cyc(0, 0, 1, 3'b000, 3'b111);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 0, 0, 3'b000, 3'b111);
      if (step_tick) begin k = i; break; end
    end
    chk("resume_gap", k, 13);

    // Ramp up/down sequence.
    cyc(1, 0, 0, 3'b000, 3'b111);
    cyc(0, 1, 0, 3'b000, 3'b111);
    for (int i = 1; i <= 1000; i++) begin
      cyc(0, 0, 0, 3'b000, 3'b111);
      if (i % 100 == 0) chk("ramp_redux", redux, exp_r[i/100-1]);
    end

    // Health saturation and partial-lane scoring.
    cyc(1, 0, 0, 3'b000, 3'b111);
    cyc(0, 1, 0, 3'b000, 3'b111);
    for (int j = 0; j < 6; j++) begin
      run_to_tick();
      cyc(0, 0, 0, 3'b111, 3'b000);
      chk("health_up", health, h_up[j]);
    end
    run_to_tick();
    cyc(0, 0, 0, 3'b110, 3'b000);
    chk("health_miss", health, 12);
    run_to_tick();
    cyc(0, 0, 0, 3'b000, 3'b111);
    chk("health_empty", health, 12);
    run_to_tick();
    cyc(0, 0, 0, 3'b110, 3'b001);
    chk("health_masked", health, 13);

    // Drain to game over.
    cyc(1, 0, 0, 3'b000, 3'b111);
    cyc(0, 1, 0, 3'b000, 3'b111);
    for (int j = 0; j < 5; j++) begin
      run_to_tick();
      cyc(0, 0, 0, 3'b000, 3'b000);
      if (j < 4) chk("health_down", health, 7 - j);
    end
    chk("over_state", state, 3);
    chk("over_flag", game_over, 1);
    chk("over_health", health, HN);
    t0 = ticks;
    for (int i = 0; i < 60; i++) cyc(0, 0, 1, 3'b000, 3'b000);
    chk("over_ticks", ticks - t0, 0);
    cyc(0, 1, 0, 3'b000, 3'b111);
    chk("over_to_idle", state, 0);
    cyc(0, 1, 0, 3'b000, 3'b111);
    chk("restart_state", state, 1);
    chk("restart_health", health, HI);

    // Start+pause together aborts; reset beats a due tick.
    cyc(0, 1, 1, 3'b000, 3'b111);
    chk("both_pulses", state, 0);
    cyc(0, 1, 0, 3'b000, 3'b111);
    for (int i = 1; i <= 19; i++) cyc(0, 0, 0, 3'b000, 3'b111);
    cyc(1, 0, 0, 3'b000, 3'b111);
    chk("rst_tick", step_tick, 0);
    chk("rst_mid_state", state, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 1000) == 0, ($urandom % 150) == 0, ($urandom % 80) == 0,
          3'($urandom % 8), 3'($urandom % 8));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dance_round_sequencer.md
Name: dance_round_sequencer

Overview:
Central game-round controller for the dance game. It owns the round state machine (idle, running, paused, game over) and generates the single-cycle step tick that advances the arrow sequence and latches the comparators. It also ramps step speed up and down at fixed intervals and keeps the health bar from per-lane hit/empty results. It takes debounced start/pause pulses and drives the display, LED-bar and arrow-generation blocks.

Parameters:
BASE_PERIOD, 50_000_000, step period in clk cycles with zero speed-up
STEP_DELTA, 5_000_000, redux increment per ramp-up event
RAMP_MAX, 40_000_000, redux ceiling for ramp-up
RAMP_MIN, 15_000_000, redux floor for ramp-down
RAMP_DOWN, 10_000_000, redux decrement per ramp-down event
RAMP_INTERVAL, 500_000_000, clk cycles between ramp events (10 s at 50 MHz)
HEALTH_INIT, 8, health at round start
HEALTH_MAX, 13, health saturation ceiling
HEALTH_MIN, 4, lowest health that does not end the round

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_pulse  in  1  one-cycle debounced start/abort request
pause_pulse  in  1  one-cycle debounced pause toggle
hits  in  3  per-lane hit flags, valid in the step_tick cycle
empties  in  3  per-lane "no arrow" flags, valid in the step_tick cycle
step_tick  out  1  one-cycle pulse per step
redux  out  27  current speed-up amount (feeds LED bar)
health  out  4  current health
state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 OVER
game_over  out  1  high while in OVER

Behaviour:
- Reset: state=IDLE, step_tick=0, redux=0, health=HEALTH_INIT, game_over=0, step counter=0, ramp counter=0, ramp direction=up. Reset takes effect on the next clk edge from any state.
- State priority each cycle: reset, then start_pulse, then pause_pulse.
- IDLE: on start_pulse go to RUN. Clear both counters, set redux=0, health=HEALTH_INIT, direction=up.
- RUN: on start_pulse go to IDLE (abort). On pause_pulse go to PAUSE. Start and pause together go to IDLE.
- PAUSE: on pause_pulse go to RUN. On start_pulse go to IDLE. Both counters, redux and health freeze. The step count resumes where it stopped.
- OVER: game_over=1, no ticks, counters frozen. On start_pulse go to IDLE. pause_pulse is ignored in OVER and IDLE.
- Step timing (RUN only):
  - period = BASE_PERIOD - redux, 27-bit unsigned.
  - The step counter increments every cycle. When counter >= period-1, assert step_tick for that cycle and clear the counter.
  - The >= compare ensures a period shrink mid-count ticks on the next cycle.
  - The first tick comes exactly `period` cycles after entering RUN from IDLE.
- Ramp (RUN only):
  - The ramp counter wraps at RAMP_INTERVAL-1 and produces a ramp event in the wrap cycle.
  - On a ramp event with direction up: if redux < RAMP_MAX then redux += STEP_DELTA, else toggle direction with no redux change.
  - On a ramp event with direction down: if redux > RAMP_MIN then redux -= RAMP_DOWN, else toggle direction with no redux change.
  - If a ramp event and step_tick fall in the same cycle, the tick uses the old period; the new redux applies from the next cycle.
  - Legal parameters require RAMP_MAX+STEP_DELTA <= BASE_PERIOD-2.
- Health (evaluated only in a step_tick cycle):
  - active = ~empties. Hits on empty lanes are masked off.
  - If active == 000: no change.
  - Else if every active lane is hit: health = min(health+1, HEALTH_MAX).
  - Else (any active lane missed): if health == HEALTH_MIN, go to OVER with health unchanged; otherwise health -= 1.
  - A step_tick that causes OVER still pulses in that cycle. No further ticks follow.
- All outputs are registered. state and game_over update on the clk edge after the causing input.

Test Plan:
(bench parameters: BASE_PERIOD=20, STEP_DELTA=2, RAMP_MAX=8, RAMP_MIN=3, RAMP_DOWN=4, RAMP_INTERVAL=100, empties=111 unless stated)
1. Reset, then start_pulse -> state=1; first step_tick 20 cycles after entry, then every 20 cycles; health=8, redux=0.
2. In RUN, pause_pulse at counter=7, hold 50 cycles, pause_pulse again -> no ticks while paused; next tick 13 cycles after resume.
3. Run 1000 cycles -> at each 100-cycle ramp event redux goes 2,4,6,8,8(direction down),4,0,0(direction up),2,4; tick spacing equals 20-redux.
4. empties=000: hits=111 on 6 ticks -> health 9,10,11,12,13,13. Then hits=110 -> 12. Then empties=111 with hits=000 -> stays 12. Then empties=001 with hits=110 -> 13.
5. empties=000, hits=000 from health 8 -> 7,6,5,4; next tick -> state=3, game_over=1, health=4, no further ticks; start_pulse -> IDLE; start_pulse -> RUN with health=8.
6. Start and pause pulses in the same cycle during RUN -> IDLE. Reset asserted mid-RUN with a tick due the same cycle -> no tick, all outputs at reset values next cycle.
